// File: rtl/risc_toy_mem.sv
// risc_toy_mem: word-addressed memory responder for the RISC_TOY core.
// I/D read ports with LAT-cycle pipelines, D write port, halt mailbox, ERR, counters.

module risc_toy_mem_pipe #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] s_q [LAT];

  if (LAT > 1) begin : g_deep
    // v_q[k] marks stage k holding a word still in flight
    logic [LAT-2:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int k = 0; k < LAT; k++)
          s_q[k] <= '0;
      end else begin
        v_q[0] <= req;
        for (int k = 1; k < LAT - 1; k++)
          v_q[k] <= v_q[k-1];
        if (req)
          s_q[0] <= d;
        for (int k = 1; k < LAT; k++)
          if (v_q[k-1])
            s_q[k] <= s_q[k-1];
      end
    end
  end else begin : g_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        s_q[0] <= '0;
      else if (req)
        s_q[0] <= d;
    end
  end

  assign q = s_q[LAT-1];

endmodule

module risc_toy_mem #(
  parameter int          AW        = 12,
  parameter int          LAT       = 1,
  parameter logic [29:0] HALT_ADDR = 30'h3FFF_FFFF
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IREQ,
  input  logic [29:0] IADDR,
  output logic [31:0] INSTR,
  input  logic        DREQ,
  input  logic        DRW,
  input  logic [29:0] DADDR,
  input  logic [31:0] DWDATA,
  output logic [31:0] DRDATA,
  output logic        HALT,
  output logic [31:0] HALT_CODE,
  output logic        ERR,
  output logic [31:0] IRD_CNT,
  output logic [31:0] DRD_CNT,
  output logic [31:0] DWR_CNT
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];

  logic        i_rng, d_rng, d_halt;
  logic        d_wr, d_rd, mem_we;
  logic [31:0] i_rdata, d_rdata;

  logic        halt_q, halt_d;
  logic [31:0] hcode_q, hcode_d;
  logic        err_q, err_d;
  logic [31:0] ird_cnt_q, ird_cnt_d;
  logic [31:0] drd_cnt_q, drd_cnt_d;
  logic [31:0] dwr_cnt_q, dwr_cnt_d;

  assign i_rng  = (IADDR[29:AW] == '0);
  assign d_rng  = (DADDR[29:AW] == '0);
  assign d_halt = (DADDR == HALT_ADDR);
  assign d_wr   = DREQ && DRW;
  assign d_rd   = DREQ && !DRW;
  assign mem_we = d_wr && d_rng && !d_halt;

  // Combinational reads sampled at the write edge give read-first order
  assign i_rdata = i_rng ? mem_q[IADDR[AW-1:0]] : 32'h0;

  always_comb begin
    d_rdata = 32'h0;
    if (d_halt)
      d_rdata = hcode_q;
    else if (d_rng)
      d_rdata = mem_q[DADDR[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem_q[DADDR[AW-1:0]] <= DWDATA;
  end

  always_comb begin
    halt_d    = halt_q;
    hcode_d   = hcode_q;
    err_d     = err_q;
    ird_cnt_d = ird_cnt_q;
    drd_cnt_d = drd_cnt_q;
    dwr_cnt_d = dwr_cnt_q;
    if (d_wr && d_halt) begin
      halt_d = 1'b1;
      if (!halt_q)
        hcode_d = DWDATA;
    end
    if (IREQ && !i_rng)
      err_d = 1'b1;
    if (DREQ && !d_rng && !d_halt)
      err_d = 1'b1;
    if (IREQ)
      ird_cnt_d = ird_cnt_q + 32'd1;
    if (d_rd)
      drd_cnt_d = drd_cnt_q + 32'd1;
    if (d_wr)
      dwr_cnt_d = dwr_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      halt_q    <= 1'b0;
      hcode_q   <= '0;
      err_q     <= 1'b0;
      ird_cnt_q <= '0;
      drd_cnt_q <= '0;
      dwr_cnt_q <= '0;
    end else begin
      halt_q    <= halt_d;
      hcode_q   <= hcode_d;
      err_q     <= err_d;
      ird_cnt_q <= ird_cnt_d;
      drd_cnt_q <= drd_cnt_d;
      dwr_cnt_q <= dwr_cnt_d;
    end
  end

  risc_toy_mem_pipe #(.LAT(LAT)) u_ipipe (
    .clk   (CLK),
    .rst_n (RSTN),
    .req   (IREQ),
    .d     (i_rdata),
    .q     (INSTR)
  );

  risc_toy_mem_pipe #(.LAT(LAT)) u_dpipe (
    .clk   (CLK),
    .rst_n (RSTN),
    .req   (d_rd),
    .d     (d_rdata),
    .q     (DRDATA)
  );

  assign HALT      = halt_q;
  assign HALT_CODE = hcode_q;
  assign ERR       = err_q;
  assign IRD_CNT   = ird_cnt_q;
  assign DRD_CNT   = drd_cnt_q;
  assign DWR_CNT   = dwr_cnt_q;

endmodule

// File: tb/tb_risc_toy_mem.sv
// tb_risc_toy_mem: directed bench for risc_toy_mem.
// Two instances share stimulus: u3 with LAT=3, u4 with LAT=4.

module tb_risc_toy_mem;

  localparam logic [29:0] HA = 30'h3FFF_FFFF;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IREQ = 1'b0;
  logic [29:0] IADDR = '0;
  logic        DREQ = 1'b0;
  logic        DRW = 1'b0;
  logic [29:0] DADDR = '0;
  logic [31:0] DWDATA = '0;

  logic [31:0] i3, d3, hc3, ic3, dc3, wc3;
  logic [31:0] i4, d4, hc4, ic4, dc4, wc4;
  logic        h3, e3, h4, e4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  risc_toy_mem #(.AW(12), .LAT(3), .HALT_ADDR(HA)) u3 (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .INSTR(i3),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(d3),
    .HALT(h3), .HALT_CODE(hc3), .ERR(e3),
    .IRD_CNT(ic3), .DRD_CNT(dc3), .DWR_CNT(wc3)
  );

  risc_toy_mem #(.AW(12), .LAT(4), .HALT_ADDR(HA)) u4 (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .INSTR(i4),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(d4),
    .HALT(h4), .HALT_CODE(hc4), .ERR(e4),
    .IRD_CNT(ic4), .DRD_CNT(dc4), .DWR_CNT(wc4)
  );

  task automatic drive(input logic ir, input logic [29:0] ia,
                       input logic dr, input logic w,
                       input logic [29:0] da, input logic [31:0] wd);
    @(negedge CLK);
    IREQ = ir; IADDR = ia;
    DREQ = dr; DRW = w; DADDR = da; DWDATA = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    #2;
    n_chk++;
    if ({i3, d3, h3, hc3, e3, ic3, dc3, wc3} !== '0) begin
      $display("FAIL reset_u3: got %h %h %b %h %b %h %h %h want all 0",
               i3, d3, h3, hc3, e3, ic3, dc3, wc3);
      n_fail++;
    end
    n_chk++;
    if ({i4, d4, h4, hc4, e4, ic4, dc4, wc4} !== '0) begin
      $display("FAIL reset_u4: got %h %h %b %h %b %h %h %h want all 0",
               i4, d4, h4, hc4, e4, ic4, dc4, wc4);
      n_fail++;
    end
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b0, '0, 1'b1, 1'b1, 30'd5, 32'hDEAD_BEEF);
    drive(1'b1, 30'd5, 1'b1, 1'b0, 30'd5, '0);
    idle();
    @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'h0 || d3 !== 32'h0) begin
      $display("FAIL wr_early_u3: got i=%h d=%h want 0 0", i3, d3);
      n_fail++;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'hDEAD_BEEF || d3 !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_lat_u3: got i=%h d=%h want deadbeef", i3, d3);
      n_fail++;
    end
    n_chk++;
    if (d4 !== 32'h0) begin
      $display("FAIL wr_early_u4: got d=%h want 0", d4);
      n_fail++;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (i4 !== 32'hDEAD_BEEF || d4 !== 32'hDEAD_BEEF) begin
      $display("FAIL wr_lat_u4: got i=%h d=%h want deadbeef", i4, d4);
      n_fail++;
    end
    n_chk++;
    if (wc3 !== 32'd1 || dc3 !== 32'd1 || ic3 !== 32'd1) begin
      $display("FAIL wr_cnt: got w=%0d d=%0d i=%0d want 1 1 1",
               wc3, dc3, ic3);
      n_fail++;
    end
  endtask

  task automatic test_read_first();
    drive(1'b0, '0, 1'b1, 1'b1, 30'd7, 32'h1111_1111);
    drive(1'b1, 30'd7, 1'b1, 1'b1, 30'd7, 32'h2222_2222);
    drive(1'b1, 30'd7, 1'b0, 1'b0, '0, '0);
    idle();
    @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'h1111_1111) begin
      $display("FAIL rf_old_u3: got %h want 11111111", i3);
      n_fail++;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'h2222_2222) begin
      $display("FAIL rf_new_u3: got %h want 22222222", i3);
      n_fail++;
    end
    n_chk++;
    if (i4 !== 32'h1111_1111) begin
      $display("FAIL rf_old_u4: got %h want 11111111", i4);
      n_fail++;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (i4 !== 32'h2222_2222) begin
      $display("FAIL rf_new_u4: got %h want 22222222", i4);
      n_fail++;
    end
  endtask

  task automatic test_pipeline();
    logic [31:0] e3x, e4x;
    for (int k = 0; k < 8; k++)
      drive(1'b0, '0, 1'b1, 1'b1, 30'(k), 32'(k));
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      e3x = (i < 3) ? 32'hDEAD_BEEF : ((i - 3 > 7) ? 32'd7 : 32'(i - 3));
      e4x = (i < 4) ? 32'hDEAD_BEEF : ((i - 4 > 7) ? 32'd7 : 32'(i - 4));
      n_chk++;
      if (d3 !== e3x) begin
        $display("FAIL pipe_u3[%0d]: got %h want %h", i, d3, e3x);
        n_fail++;
      end
      n_chk++;
      if (d4 !== e4x) begin
        $display("FAIL pipe_u4[%0d]: got %h want %h", i, d4, e4x);
        n_fail++;
      end
      IREQ = 1'b0;
      DRW = 1'b0;
      DREQ = (i < 8);
      DADDR = (i < 8) ? 30'(i) : '0;
    end
  endtask

  task automatic test_halt_err();
    drive(1'b0, '0, 1'b1, 1'b1, HA, 32'h0000_00AA);
    drive(1'b0, '0, 1'b1, 1'b1, HA, 32'h0000_0055);
    drive(1'b0, '0, 1'b1, 1'b0, HA, '0);
    idle();
    repeat (2) @(posedge CLK); #1;
    n_chk++;
    if (h3 !== 1'b1 || hc3 !== 32'hAA || e3 !== 1'b0) begin
      $display("FAIL halt: got h=%b code=%h err=%b want 1 aa 0",
               h3, hc3, e3);
      n_fail++;
    end
    n_chk++;
    if (d3 !== 32'hAA) begin
      $display("FAIL halt_read: got %h want aa", d3);
      n_fail++;
    end
    drive(1'b0, '0, 1'b1, 1'b0, 30'h1000, '0);
    idle();
    @(posedge CLK); #1;
    n_chk++;
    if (e3 !== 1'b1) begin
      $display("FAIL oor_err: got %b want 1", e3);
      n_fail++;
    end
    @(posedge CLK); #1;
    n_chk++;
    if (d3 !== 32'h0) begin
      $display("FAIL oor_data: got %h want 0", d3);
      n_fail++;
    end
    drive(1'b0, '0, 1'b1, 1'b1, 30'h1000, 32'h99);
    drive(1'b1, 30'd0, 1'b0, 1'b0, '0, '0);
    idle();
    repeat (2) @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'h0) begin
      $display("FAIL oor_nowrite: got %h want 0", i3);
      n_fail++;
    end
    n_chk++;
    if (wc3 !== 32'd14 || dc3 !== 32'd11 || ic3 !== 32'd4) begin
      $display("FAIL cnt_total: got w=%0d d=%0d i=%0d want 14 11 4",
               wc3, dc3, ic3);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 30'd6, 1'b1, 1'b0, 30'd3, '0);
    @(posedge CLK); #2;
    RSTN = 1'b0;
    #1;
    n_chk++;
    if ({i3, d3, h3, hc3, e3, ic3, dc3, wc3} !== '0) begin
      $display("FAIL rst_mid_u3: got %h %h %b %h %b %h %h %h want all 0",
               i3, d3, h3, hc3, e3, ic3, dc3, wc3);
      n_fail++;
    end
    n_chk++;
    if ({i4, d4, h4, hc4, e4, ic4, dc4, wc4} !== '0) begin
      $display("FAIL rst_mid_u4: got %h %h %b %h %b %h %h %h want all 0",
               i4, d4, h4, hc4, e4, ic4, dc4, wc4);
      n_fail++;
    end
    IREQ = 1'b0;
    DREQ = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (6) @(posedge CLK); #1;
    n_chk++;
    if ({i3, d3, i4, d4} !== '0 || {ic3, dc3, wc3} !== '0) begin
      $display("FAIL rst_hold: got i=%h d=%h i4=%h d4=%h c=%h/%h/%h want 0",
               i3, d3, i4, d4, ic3, dc3, wc3);
      n_fail++;
    end
    drive(1'b1, 30'd6, 1'b1, 1'b0, 30'd3, '0);
    idle();
    repeat (2) @(posedge CLK); #1;
    n_chk++;
    if (i3 !== 32'd6 || d3 !== 32'd3) begin
      $display("FAIL rst_array: got i=%h d=%h want 6 3", i3, d3);
      n_fail++;
    end
  endtask

  task automatic test_counter_wrap();
    @(negedge CLK);
    force u3.dwr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release u3.dwr_cnt_q;
    #1;
    n_chk++;
    if (wc3 !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_pre: got %h want ffffffff", wc3);
      n_fail++;
    end
    drive(1'b0, '0, 1'b1, 1'b1, 30'd10, 32'h1234);
    idle();
    n_chk++;
    if (wc3 !== 32'h0) begin
      $display("FAIL wrap: got %h want 0", wc3);
      n_fail++;
    end
    n_chk++;
    if (wc4 !== 32'd1) begin
      $display("FAIL wrap_u4: got %h want 1", wc4);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_pipeline();
    test_halt_err();
    test_reset_mid();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
